// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional hardwired zero register, pending-bit
// scoreboard and sequential clear engine. Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 31,
  parameter int HAS_ZERO = 1
) (
  input  logic                 Clk,
  input  logic                 ResetL,
  input  logic                 Clear,
  output logic                 Ready,
  input  logic [NR*ADDR_W-1:0] RA,
  output logic [NR*DATA_W-1:0] Bus,
  output logic [NR-1:0]        Busy,
  input  logic [ADDR_W-1:0]    RW,
  input  logic [DATA_W-1:0]    BusW,
  input  logic                 RegWr,
  input  logic [ADDR_W-1:0]    RsvAddr,
  input  logic                 Rsv
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(NUM_REGS - 1);
  localparam bit                ZERO_EN  = (HAS_ZERO != 0);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic                run;
  logic                wr_ok;
  logic                rsv_ok;

  assign run    = (state_q == ST_RUN);
  assign wr_ok  = run && RegWr && !(ZERO_EN && (RW == ZERO_A));
  assign rsv_ok = run && Rsv && !(ZERO_EN && (RsvAddr == ZERO_A));

  // All state moves on the falling edge; the array itself is only zeroed by the clear engine.
  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(negedge Clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    mem_we  = 1'b0;
    mem_wa  = RW;
    mem_wd  = BusW;
    Ready   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = idx_q;
        mem_wd = '0;
        pend_d = '0;
        if (Clear) begin
          idx_d = '0;
        end else if (idx_q == LAST_A) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        Ready = 1'b1;
        if (Clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          pend_d  = '0;
        end else begin
          mem_we = wr_ok;
          if (wr_ok) begin
            pend_d[RW] = 1'b0;
          end
          // Reservation applied after the write: it belongs to a younger instruction.
          if (rsv_ok) begin
            pend_d[RsvAddr] = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic [DATA_W-1:0] rd;
    logic              bsy;

    assign ra      = RA[g*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_EN && (ra == ZERO_A);

    always_comb begin
      rd  = mem_q[ra];
      bsy = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (RegWr && run && (RW == ra) && !is_zero) begin
        rd = BusW;
        if (!(Rsv && (RsvAddr == ra))) begin
          bsy = 1'b0;
        end
      end
`endif
      if (!run || is_zero) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign Bus[g*DATA_W +: DATA_W] = rd;
    assign Busy[g]                 = bsy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array-based reference model;
// directed scenarios first, then random traffic with occasional Clear and reset.
module tb_regfile_scoreboard;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NR     = 2;
  localparam int NREGS  = 32;
  localparam int ZR     = 31;

  logic                 Clk;
  logic                 ResetL;
  logic                 Clear;
  logic                 Ready;
  logic [NR*ADDR_W-1:0] RA;
  logic [NR*DATA_W-1:0] Bus;
  logic [NR-1:0]        Busy;
  logic [ADDR_W-1:0]    RW;
  logic [DATA_W-1:0]    BusW;
  logic                 RegWr;
  logic [ADDR_W-1:0]    RsvAddr;
  logic                 Rsv;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .ZERO_REG(ZR), .HAS_ZERO(1)
  ) dut (
    .Clk(Clk), .ResetL(ResetL), .Clear(Clear), .Ready(Ready),
    .RA(RA), .Bus(Bus), .Busy(Busy),
    .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .RsvAddr(RsvAddr), .Rsv(Rsv)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mreg [NREGS];
  bit                mpend [NREGS];
  int                clear_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      mreg[r]  = '0;
      mpend[r] = 1'b0;
    end
    clear_left = NREGS;
  endtask

  task automatic idle();
    RegWr = 1'b0;
    Rsv   = 1'b0;
    Clear = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rsel(input int p);
    return RA[p*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] busp(input int p);
    return Bus[p*DATA_W +: DATA_W];
  endfunction

  // Called at negedge+1: reset pulse sits entirely between falling edges.
  task automatic do_reset();
    ResetL = 1'b0;
    #2;
    chk("rst_ready", Ready, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_bus", Bus, 0);
    model_clear();
    ResetL = 1'b1;
  endtask

  // Check combinational outputs against the model, then advance one falling edge.
  task automatic cycle();
    logic [DATA_W-1:0] eb;
    logic              ey;
    int                a;
    #1;
    chk("ready", Ready, clear_left == 0);
    for (int p = 0; p < NR; p++) begin
      a  = int'(rsel(p));
      eb = '0;
      ey = 1'b0;
      if (clear_left == 0 && a != ZR) begin
        eb = mreg[a];
        ey = mpend[a];
`ifdef REGFILE_BYPASS_EN
        if (RegWr && int'(RW) == a) begin
          eb = BusW;
          if (!(Rsv && int'(RsvAddr) == a)) ey = 1'b0;
        end
`endif
      end
      chk($sformatf("bus%0d", p), busp(p), eb);
      chk($sformatf("busy%0d", p), Busy[p], ey);
    end
    @(negedge Clk);
    if (clear_left > 0) begin
      if (Clear) clear_left = NREGS;
      else clear_left--;
    end else if (Clear) begin
      model_clear();
    end else begin
      if (RegWr && int'(RW) != ZR) begin
        mreg[RW]  = BusW;
        mpend[RW] = 1'b0;
      end
      if (Rsv && int'(RsvAddr) != ZR) mpend[RsvAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    while (!Ready && cnt < 40) begin
      cycle();
      cnt++;
    end
    chk(tag, cnt, NREGS);
  endtask

  function automatic logic [ADDR_W-1:0] raddr();
    case ($urandom_range(0, 3))
      0:       return ADDR_W'(ZR);
      1, 2:    return ADDR_W'($urandom_range(0, 7));
      default: return ADDR_W'($urandom);
    endcase
  endfunction

  initial begin
    ResetL  = 1'b1;
    RA      = '0;
    RW      = '0;
    BusW    = '0;
    RsvAddr = '0;
    idle();
    model_clear();
    @(negedge Clk);
    #1;

    // Reset release: clear takes 32 edges, then everything reads zero.
    do_reset();
    count_clear("t1_clr_len");
    for (int a = 0; a < NREGS; a += 2) begin
      RA = {ADDR_W'(a + 1), ADDR_W'(a)};
      #1;
      chk("t1_zero0", busp(0), 0);
      chk("t1_zero1", busp(1), 0);
      cycle();
    end

    // Write then read; zero register ignores writes.
    RegWr = 1'b1; RW = 5; BusW = 64'hDEAD_BEEF;
    cycle();
    idle(); RA = {ADDR_W'(0), ADDR_W'(5)};
    #1; chk("t2_rd5", busp(0), 64'hDEAD_BEEF);
    cycle();
    RegWr = 1'b1; RW = 31; BusW = 64'd1;
    cycle();
    idle(); RA = {ADDR_W'(31), ADDR_W'(5)};
    #1; chk("t2_rd31", busp(1), 0);
    cycle();

    // Reservation, write+reserve same register, then plain write.
    Rsv = 1'b1; RsvAddr = 7;
    cycle();
    idle(); RA = {ADDR_W'(0), ADDR_W'(7)};
    #1; chk("t3_busy", Busy[0], 1);
    RegWr = 1'b1; RW = 7; BusW = 64'd77; Rsv = 1'b1; RsvAddr = 7;
    cycle();
    idle();
    #1; chk("t3_busy_wr_rsv", Busy[0], 1);
    chk("t3_data", busp(0), 64'd77);
    RegWr = 1'b1; RW = 7; BusW = 64'd78;
    cycle();
    idle();
    #1; chk("t3_busy_cleared", Busy[0], 0);
    cycle();

    // Same-cycle write and read.
    RegWr = 1'b1; RW = 3; BusW = 64'd9;
    cycle();
    RW = 3; BusW = 64'd42; RA = {ADDR_W'(0), ADDR_W'(3)};
`ifdef REGFILE_BYPASS_EN
    #1; chk("t4_same_cycle", busp(0), 64'd42);
`else
    #1; chk("t4_same_cycle", busp(0), 64'd9);
`endif
    cycle();
    idle();
    #1; chk("t4_next", busp(0), 64'd42);
    cycle();

    // Clear pulse in RUN; writes during clear ignored.
    RegWr = 1'b1; RW = 5; BusW = 64'hAB; Rsv = 1'b1; RsvAddr = 7;
    cycle();
    idle(); Clear = 1'b1;
    cycle();
    Clear = 1'b0; RegWr = 1'b1; RW = 5; BusW = 64'hFF;
    count_clear("t5_clr_len");
    idle(); RA = {ADDR_W'(7), ADDR_W'(5)};
    #1; chk("t5_reg5", busp(0), 0);
    chk("t5_busy7", Busy[1], 0);
    cycle();

    // Reset in the middle of a clear restarts it.
    do_reset();
    repeat (10) cycle();
    do_reset();
    count_clear("t6_clr_len");

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      RegWr   = ($urandom_range(0, 1) == 1);
      RW      = raddr();
      BusW    = {$urandom, $urandom};
      Rsv     = ($urandom_range(0, 2) == 0);
      RsvAddr = raddr();
      Clear   = ($urandom_range(0, 299) == 0);
      RA      = {raddr(), raddr()};
      if ($urandom_range(0, 799) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
